fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 512: instruction memory depth in words; PC is a word index modulo DEPTH.
REQ-002 Parameter RESET_PC, default 0: word index of the first fetch after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 fetch_en  input  1  high permits new fetch issues; low freezes issuing (IDLE).
REQ-006 redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 redirect_pc  input  32  target word index; only the low log2(DEPTH) bits are used, upper bits are ignored.
REQ-008 imem_pc  output  32  address to the synchronous instruction memory; upper bits are always zero.
REQ-009 imem_instruction  input  32  memory read data; holds mem[imem_pc of the previous cycle].
REQ-010 inst_valid  output  1  inst_out/inst_pc hold a fetched instruction.
REQ-011 inst_ready  input  1  decode accepts; transfer occurs when inst_valid && inst_ready.
REQ-012 inst_out  output  32  fetched instruction word.
REQ-013 inst_pc  output  32  word index inst_out was fetched from.

Function
REQ-014 Memory latency is exactly 1 cycle: data for the imem_pc driven in cycle N is captured from imem_instruction at the end of cycle N+1.
REQ-015 A 2-entry FIFO buffers the instruction and PC; inst_valid = (count != 0); inst_out and inst_pc come from the head.
REQ-016 An issue occurs in cycle N when state is RUN and (count + inflight - pop) < 2, where pop = inst_valid && inst_ready; on issue, inflight is set for cycle N+1 and the pc register advances to (pc+1) mod DEPTH.
REQ-017 imem_pc always equals the pc register; it is held while not issuing, and responses not tagged inflight are discarded.
REQ-018 An inflight response is pushed into the FIFO with its PC at the end of the cycle following the issue; a push and a pop in the same cycle leave count unchanged.
REQ-019 States: IDLE (fetch_en=0), RUN (issuing allowed), STALL (buffer plus inflight equals 2).
REQ-020 State transitions: IDLE->RUN when fetch_en=1; RUN->STALL when the issue condition is false with fetch_en=1; STALL->RUN when it becomes true; any state->IDLE when fetch_en=0.
REQ-021 In IDLE, an already-inflight response is still captured.
REQ-022 On redirect_valid, the FIFO is flushed, the inflight response is dropped, the pc register is set to redirect_pc, and no issue occurs in that cycle; inst_valid is 0 in the following cycle.
REQ-023 When redirect and pop occur in the same cycle, the redirect wins and the pop is void.
REQ-024 The PC wraps from DEPTH-1 to 0 with no error indication.
REQ-025 The FIFO never overflows; a push into a full FIFO is impossible by construction, and an assertion checks it.
REQ-026 Throughput with inst_ready held high and no redirects is one instruction per cycle.

Reset
REQ-027 While rst=1: pc=RESET_PC, count=0, inflight=0, state=IDLE, inst_valid=0, inst_out=0, inst_pc=0, imem_pc=RESET_PC.
REQ-028 rst overrides redirect_valid and fetch_en.
REQ-029 rst asserted mid-operation discards all buffered and inflight instructions at that clock edge.
REQ-030 The first issue is in the first cycle after rst=0 with fetch_en=1; inst_valid rises 2 cycles after that issue cycle.

Structure
REQ-031 Package fetch_pkg holds DEPTH, RESET_PC, PC_W=$clog2(DEPTH), the state enum {IDLE, RUN, STALL}, and the 32-bit word width constant.
REQ-032 The 2-entry FIFO is sub-module fetch_buffer (push, pop, flush, data/pc in and out, count).
REQ-033 Pc register, inflight flag and FSM live in fetch_unit.

Verification
REQ-034 Reset release, fetch_en=1, inst_ready=1, mem[0..6] preloaded -> inst_out = mem[0], mem[1], ... on consecutive cycles starting at cycle 2, with inst_pc = 0, 1, 2, ...
REQ-035 inst_ready=0 for 5 cycles -> count saturates at 2, imem_pc holds at 2, state=STALL; on inst_ready=1 -> mem[0], mem[1], mem[2] delivered in order with none lost or duplicated.
REQ-036 redirect_pc=0x105 while pop and inflight are active -> next cycle inst_valid=0, imem_pc=0x105; 2 cycles later inst_pc=0x105; the dropped word is never presented.
REQ-037 Run from redirect_pc=510 -> inst_pc sequence 510, 511, 0, 1.
REQ-038 rst asserted for 1 cycle with 2 entries buffered -> inst_valid=0, imem_pc=0 next cycle; the fetch restarts from mem[0].
REQ-039 fetch_en toggled low for 3 cycles mid-stream -> at most one extra instruction captured; no gaps or duplicates in the inst_pc sequence after resuming.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and PC arithmetic for the instruction fetch unit.
package fetch_pkg;
    localparam int DEPTH    = 512;
    localparam int RESET_PC = 0;
    localparam int PC_W     = $clog2(DEPTH);
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    // Word-index increment modulo the memory depth.
    function automatic int unsigned wrap_inc(input int unsigned pc, input int unsigned depth);
        return (pc == depth - 1) ? 0 : pc + 1;
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction/PC FIFO between the instruction memory and decode.
module fetch_buffer #(
    parameter int PC_W = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [fetch_pkg::WORD_W-1:0] push_data,
    input  logic [PC_W-1:0]             push_pc,
    output logic [fetch_pkg::WORD_W-1:0] head_data,
    output logic [PC_W-1:0]             head_pc,
    output logic [1:0]                  count
);
    import fetch_pkg::*;

    logic       rd_ptr_reg;
    logic       wr_ptr_reg;
    logic [1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : slot_g
            localparam logic SLOT = 1'(gi);
            logic [WORD_W-1:0] data_reg;
            logic [PC_W-1:0]   pc_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                    pc_reg   <= '0;
                end else if (push && !flush && (wr_ptr_reg == SLOT)) begin
                    data_reg <= push_data;
                    pc_reg   <= push_pc;
                end
            end
        end
    endgenerate

    assign head_data = rd_ptr_reg ? slot_g[1].data_reg : slot_g[0].data_reg;
    assign head_pc   = rd_ptr_reg ? slot_g[1].pc_reg   : slot_g[0].pc_reg;
    assign count     = count_reg;

    // Issue throttling keeps at most one free-slot's worth of data in flight.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && count_reg == 2'd2))
                else $error("fetch_buffer: push into full buffer");
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one-cycle memory response tracking, and a small decode buffer.
module fetch_unit #(
    parameter int DEPTH    = fetch_pkg::DEPTH,
    parameter int RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);
    import fetch_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]     pc_reg;
    logic [AW-1:0]     pc_next;
    logic [AW-1:0]     inflight_pc_reg;
    logic              inflight_reg;
    fetch_state_t      state_reg;

    logic [1:0]        count;
    logic [WORD_W-1:0] head_data;
    logic [AW-1:0]     head_pc;
    logic              pop;
    logic              push;
    logic              room;
    logic              issue;
    logic [2:0]        occupancy;

    assign inst_valid = (count != 2'd0);
    // A redirect voids any same-cycle acceptance and the response returning this cycle.
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push       = inflight_reg && !redirect_valid;
    assign occupancy  = {1'b0, count} + {2'b0, inflight_reg} - {2'b0, pop};
    assign room       = (occupancy < 3'd2);
    // Qualified by fetch_en directly so the first issue lands in the first cycle after reset.
    assign issue      = fetch_en && room && !redirect_valid;
    assign pc_next    = AW'(wrap_inc(32'(pc_reg), DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= AW'(RESET_PC);
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            state_reg       <= IDLE;
        end else begin
            inflight_reg <= issue;
            if (issue) inflight_pc_reg <= pc_reg;

            if (redirect_valid)
                pc_reg <= redirect_pc[AW-1:0];
            else if (issue)
                pc_reg <= pc_next;

            if (!fetch_en) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE:    state_reg <= RUN;
                    RUN:     if (!room) state_reg <= STALL;
                    STALL:   if (room)  state_reg <= RUN;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    fetch_buffer #(
        .PC_W (AW)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (imem_instruction),
        .push_pc   (inflight_pc_reg),
        .head_data (head_data),
        .head_pc   (head_pc),
        .count     (count)
    );

    assign imem_pc  = 32'(pc_reg);
    assign inst_out = head_data;
    assign inst_pc  = 32'(head_pc);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by randomized fetch/ready/redirect/reset traffic.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    logic [31:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int exp_q[$];
    int last_pc = 0;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_out         (inst_out),
        .inst_pc          (inst_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: one cycle of read latency.
    always @(posedge clk) imem_instruction <= mem[imem_pc[8:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected delivery order: consecutive word indices from the last restart point.
    task automatic refill();
        while (exp_q.size() < 8) begin
            last_pc = (last_pc + 1) % DEPTH;
            exp_q.push_back(last_pc);
        end
    endtask

    task automatic restart(input int p);
        exp_q.delete();
        last_pc = p % DEPTH;
        exp_q.push_back(last_pc);
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    // Monitor: every accepted instruction must be the next expected PC and its memory word.
    always @(negedge clk) begin
        if (!rst) begin
            check("imem_pc_upper_zero", imem_pc >> 9, 32'd0);
            if (!redirect_valid && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL xfer_unexpected: actual pc %0h required no transfer", inst_pc);
                end else begin
                    int p;
                    p = exp_q.pop_front();
                    check("xfer_pc", inst_pc, 32'(p));
                    check("xfer_data", inst_out, mem[p]);
                    xfers++;
                    $display("[TB] xfer pc=%0h inst=%08h", inst_pc, inst_out);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: actual still running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x0;
        int r;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        restart(0);

        // Reset holds despite fetch_en and redirect.
        repeat (2) step();
        fetch_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h55;
        step();
        @(negedge clk);
        check("rst_imem_pc", imem_pc, 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // Release: first word appears in cycle 2, then one per cycle.
        step();
        rst = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        restart(0);
        @(negedge clk);
        check("c0_valid", 32'(inst_valid), 32'd0);
        step();
        @(negedge clk);
        check("c1_valid", 32'(inst_valid), 32'd0);
        step();
        @(negedge clk);
        check("c2_valid", 32'(inst_valid), 32'd1);
        check("c2_inst_pc", inst_pc, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check("throughput_valid", 32'(inst_valid), 32'd1);
        end

        // Backpressure: buffer saturates and the fetch address holds.
        step();
        rst = 1'b1;
        restart(0);
        step();
        rst = 1'b0;
        inst_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("stall_imem_pc", imem_pc, 32'd2);
        check("stall_valid", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b1;
        repeat (6) step();

        // Redirect with a pop and an inflight response; upper target bits ignored.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FE00 | 32'h105;
        restart(32'h105);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_valid", 32'(inst_valid), 32'd0);
        check("redir_imem_pc", imem_pc, 32'h105);
        repeat (2) step();
        @(negedge clk);
        check("redir_inst_pc", inst_pc, 32'h105);
        repeat (4) step();

        // Wrap from the top of memory.
        redirect_valid = 1'b1;
        redirect_pc = 32'd510;
        restart(510);
        step();
        redirect_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("wrap_first_pc", inst_pc, 32'd510);
        repeat (6) step();

        // Reset with two entries buffered.
        inst_ready = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        restart(0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(inst_valid), 32'd0);
        check("midrst_imem_pc", imem_pc, 32'd0);
        inst_ready = 1'b1;
        repeat (10) step();

        // Pause issuing mid-stream.
        fetch_en = 1'b0;
        repeat (3) step();
        fetch_en = 1'b1;
        repeat (10) step();

        // Randomized traffic.
        x0 = xfers;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = 1'b0;
            redirect_valid = 1'b0;
            inst_ready = ($urandom_range(0, 3) != 0);
            fetch_en = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 99);
            if (r == 0) begin
                rst = 1'b1;
                restart(0);
            end else if (r < 4) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
                restart(int'(redirect_pc[8:0]));
            end
        end
        step();
        rst = 1'b0;
        redirect_valid = 1'b0;
        check("random_progress", 32'((xfers - x0) > 500), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
